// File: rtl/mux9_rr_arbiter_pkg.sv
// Shared types and helpers for the 9-lane round-robin arbiter.
// Lane indices are 0..8; every increment wraps modulo nine.
package mux9_pkg;

  localparam int NUM_LANES = 9;
  localparam int SEL_W     = 4;

  typedef logic [SEL_W-1:0] lane_idx_t;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_t;

  function automatic lane_idx_t next_idx(
    input lane_idx_t idx
  );
    if (idx >= lane_idx_t'(NUM_LANES - 1))
      return '0;
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/mux9_rr_arbiter_if.sv
// Lane-side and consumer-side bundle of the 9-lane arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface mux9_rr_arbiter_if #(
  parameter int DATA_W = 16
);
  import mux9_pkg::*;

  logic [NUM_LANES-1:0] req;
  logic [DATA_W-1:0]    din_a;
  logic [DATA_W-1:0]    din_b;
  logic [DATA_W-1:0]    din_c;
  logic [DATA_W-1:0]    din_d;
  logic [DATA_W-1:0]    din_e;
  logic [DATA_W-1:0]    din_f;
  logic [DATA_W-1:0]    din_g;
  logic [DATA_W-1:0]    din_h;
  logic [DATA_W-1:0]    din_i;
  logic [NUM_LANES-1:0] ack;
  lane_idx_t            sel;
  logic [DATA_W-1:0]    out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;

  modport master (
    output req,
    output din_a, din_b, din_c,
    output din_d, din_e, din_f,
    output din_g, din_h, din_i,
    output out_ready,
    input  ack,
    input  sel,
    input  out_data,
    input  out_valid,
    input  busy
  );

  modport slave (
    input  req,
    input  din_a, din_b, din_c,
    input  din_d, din_e, din_f,
    input  din_g, din_h, din_i,
    input  out_ready,
    output ack,
    output sel,
    output out_data,
    output out_valid,
    output busy
  );

endinterface

// File: rtl/mux9_rr_arbiter_pick.sv
// Circular priority pick over nine requests, starting at ptr.
// Purely combinational; any flags that some lane is requesting.
module rr_pick9
  import mux9_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  lane_idx_t            ptr,
  output lane_idx_t            winner,
  output logic                 any
);

  function automatic lane_idx_t lane_at(
    input lane_idx_t base,
    input int        ofs
  );
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_LANES)
      s = s - NUM_LANES;
    return lane_idx_t'(s);
  endfunction

  // Scan farthest-first so the nearest hit overwrites.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (req[lane_at(ptr, k)]) begin
        winner = lane_at(ptr, k);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux9to1.sv
// 9-to-1 word multiplexer for the lane datapath.
// Out-of-range selects yield zero.
module mux9to1 #(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] h,
  input  logic [DATA_W-1:0] i,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      4'd0:    y = a;
      4'd1:    y = b;
      4'd2:    y = c;
      4'd3:    y = d;
      4'd4:    y = e;
      4'd5:    y = f;
      4'd6:    y = g;
      4'd7:    y = h;
      4'd8:    y = i;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux9_rr_arbiter.sv
// Round-robin arbiter/sequencer for the 9-to-1 lane datapath.
// Define ARB_BURST_EN to let one lane win up to MAX_BURST times in a row.
module mux9_rr_arbiter
  import mux9_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  mux9_rr_arbiter_if.slave    bus
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("MAX_BURST must be 1..15");
  end

  arb_state_t           state;
  arb_state_t           state_n;
  lane_idx_t            ptr;
  lane_idx_t            ptr_n;
  lane_idx_t            sel_q;
  lane_idx_t            sel_n;
  lane_idx_t            ptr_upd;
  lane_idx_t            pick_ptr;
  lane_idx_t            winner;
  logic [NUM_LANES-1:0] ack_q;
  logic [NUM_LANES-1:0] ack_n;
  logic [DATA_W-1:0]    data_q;
  logic [DATA_W-1:0]    data_n;
  logic [DATA_W-1:0]    mux_y;
  logic                 valid_q;
  logic                 valid_n;
  logic                 any;
  logic                 xfer;
  logic                 grant;

`ifdef ARB_BURST_EN
  logic [3:0]           cnt;
  logic [3:0]           cnt_n;
  logic [3:0]           cnt_base;
  logic                 stay;
`endif

  assign xfer  = (state == HOLD) && valid_q
               && bus.out_ready;
  assign grant = (state == IDLE) || xfer;

  // Pointer the arbitration uses if this cycle transfers.
  always_comb begin
`ifdef ARB_BURST_EN
    stay     = bus.req[sel_q]
             && (cnt < 4'(MAX_BURST));
    ptr_upd  = stay ? sel_q : next_idx(sel_q);
    cnt_base = (xfer && !stay) ? 4'd0 : cnt;
`else
    ptr_upd  = next_idx(sel_q);
`endif
    pick_ptr = xfer ? ptr_upd : ptr;
  end

  rr_pick9 u_pick (
    .req    (bus.req),
    .ptr    (pick_ptr),
    .winner (winner),
    .any    (any)
  );

  mux9to1 #(
    .DATA_W (DATA_W)
  ) u_mux (
    .sel (winner),
    .a   (bus.din_a),
    .b   (bus.din_b),
    .c   (bus.din_c),
    .d   (bus.din_d),
    .e   (bus.din_e),
    .f   (bus.din_f),
    .g   (bus.din_g),
    .h   (bus.din_h),
    .i   (bus.din_i),
    .y   (mux_y)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel_q;
    ack_n   = '0;
    data_n  = data_q;
    valid_n = valid_q;
`ifdef ARB_BURST_EN
    cnt_n   = cnt;
`endif
    if (grant) begin
      if (xfer)
        ptr_n = ptr_upd;
`ifdef ARB_BURST_EN
      cnt_n = cnt_base;
`endif
      if (any) begin
        state_n = HOLD;
        sel_n   = winner;
        ack_n   = {{(NUM_LANES-1){1'b0}}, 1'b1}
                  << winner;
        data_n  = mux_y;
        valid_n = 1'b1;
`ifdef ARB_BURST_EN
        cnt_n   = (winner == sel_q)
                ? cnt_base + 4'd1 : 4'd1;
`endif
      end else begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      sel_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef ARB_BURST_EN
      cnt     <= '0;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      sel_q   <= sel_n;
      ack_q   <= ack_n;
      data_q  <= data_n;
      valid_q <= valid_n;
`ifdef ARB_BURST_EN
      cnt     <= cnt_n;
`endif
    end
  end

  assign bus.ack       = ack_q;
  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = valid_q;

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// Self-checking bench for mux9_rr_arbiter.
// Directed scenarios plus random traffic against a behavioural model.
module tb_mux9_rr_arbiter;
  import mux9_pkg::*;

  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;
`ifdef ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DATA_W-1:0] din [9];

  mux9_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

  assign bus.din_a = din[0];
  assign bus.din_b = din[1];
  assign bus.din_c = din[2];
  assign bus.din_d = din[3];
  assign bus.din_e = din[4];
  assign bus.din_f = din[5];
  assign bus.din_g = din[6];
  assign bus.din_h = din[7];
  assign bus.din_i = din[8];

  mux9_rr_arbiter #(
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int          m_ptr;
  int          m_sel;
  int          m_cnt;
  logic        m_valid;
  logic [15:0] m_data;
  logic [8:0]  m_ack;

  // Next observable state, from the rules in plain arithmetic.
  task automatic model_step();
    int w;
    if (rst) begin
      m_ptr = 0; m_sel = 0; m_cnt = 0;
      m_valid = 1'b0; m_data = '0; m_ack = '0;
      return;
    end
    m_ack = '0;
    if (!m_valid || bus.out_ready) begin
      if (m_valid) begin
        if (BURST && bus.req[m_sel] && m_cnt < MAX_BURST)
          m_ptr = m_sel;
        else begin
          m_ptr = (m_sel + 1) % 9;
          m_cnt = 0;
        end
      end
      w = -1;
      for (int k = 0; k < 9; k++)
        if (w < 0 && bus.req[(m_ptr + k) % 9])
          w = (m_ptr + k) % 9;
      if (w >= 0) begin
        m_cnt   = (w == m_sel) ? m_cnt + 1 : 1;
        m_sel   = w;
        m_data  = din[w];
        m_ack   = 9'(1) << w;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [30:0] dut_vec();
    return {bus.ack, bus.sel, bus.out_data,
            bus.out_valid, bus.busy};
  endfunction

  function automatic logic [30:0] mdl_vec();
    return {m_ack, 4'(m_sel), m_data,
            m_valid, m_valid};
  endfunction

  task automatic rand_din();
    for (int k = 0; k < 9; k++)
      din[k] = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 9'h1FF;
    bus.out_ready = 1'b1;
    rand_din();
    tick();
    tick();
    vectors++;
    if (dut_vec() !== 31'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h exp=0", dut_vec());
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.sel !== 4'd0 || bus.ack !== 9'h001 ||
        bus.out_valid !== 1'b1 || bus.out_data !== din[0]) begin
      miscompares++;
      $display("FAIL reset_first_capture got sel=%0d ack=%h v=%b d=%h exp sel=0 ack=001 v=1 d=%h",
               bus.sel, bus.ack, bus.out_valid, bus.out_data, din[0]);
    end
    vectors++;
    if (dut_vec() !== mdl_vec()) begin
      miscompares++;
      $display("FAIL reset_model got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_single_lane();
    bus.req = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle got v=%b busy=%b exp 0", bus.out_valid, bus.busy);
    end
    din[4] = 16'h9873;
    bus.req = 9'h010;
    tick();
    vectors++;
    if (bus.ack !== 9'h010 || bus.out_data !== 16'h9873 ||
        bus.sel !== 4'd4 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_capture got ack=%h d=%h sel=%0d v=%b exp ack=010 d=9873 sel=4 v=1",
               bus.ack, bus.out_data, bus.sel, bus.out_valid);
    end
    bus.req = '0;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.ack !== 9'h000) begin
      miscompares++;
      $display("FAIL single_drop got v=%b ack=%h exp v=0 ack=000", bus.out_valid, bus.ack);
    end
    tick();
    vectors++;
    if (dut_vec() !== mdl_vec()) begin
      miscompares++;
      $display("FAIL single_idle_model got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_rotation();
    int n;
    int exp_sel;
    n = BURST ? 9 * MAX_BURST + 1 : 10;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 9'h1FF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      rand_din();
      tick();
      exp_sel = BURST ? (i / MAX_BURST) % 9 : i % 9;
      vectors++;
      if (bus.sel !== 4'(exp_sel) || bus.ack !== (9'(1) << exp_sel)) begin
        miscompares++;
        $display("FAIL rotation step %0d got sel=%0d ack=%h exp sel=%0d",
                 i, bus.sel, bus.ack, exp_sel);
      end
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL rotation_model step %0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    int acks;
    logic [15:0] a0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rand_din();
    bus.req = 9'h003;
    bus.out_ready = 1'b0;
    tick();
    a0 = din[0];
    acks = (bus.ack != 9'h0) ? 1 : 0;
    vectors++;
    if (bus.ack !== 9'h001 || bus.out_data !== a0) begin
      miscompares++;
      $display("FAIL bp_capture got ack=%h d=%h exp ack=001 d=%h", bus.ack, bus.out_data, a0);
    end
    for (int i = 0; i < 5; i++) begin
      din[0] = 16'($urandom);
      tick();
      if (bus.ack != 9'h0) acks++;
      vectors++;
      if (bus.out_data !== a0 || bus.out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got d=%h v=%b exp d=%h v=1",
                 i, bus.out_data, bus.out_valid, a0);
      end
    end
    vectors++;
    if (acks !== 1) begin
      miscompares++;
      $display("FAIL bp_ack_count got=%0d exp=1", acks);
    end
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (bus.sel !== (BURST ? 4'd0 : 4'd1)) begin
      miscompares++;
      $display("FAIL bp_release got sel=%0d exp=%0d", bus.sel, BURST ? 0 : 1);
    end
  endtask

  task automatic test_reset_mid();
    bus.req = 9'h1F0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.sel !== 4'd4) begin
      miscompares++;
      $display("FAIL mid_setup got v=%b sel=%0d exp v=1 sel=4", bus.out_valid, bus.sel);
    end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (dut_vec() !== 31'h0) begin
      miscompares++;
      $display("FAIL mid_reset got=%h exp=0", dut_vec());
    end
    rst = 1'b0;
    bus.req = 9'h1FF;
    rand_din();
    tick();
    vectors++;
    if (bus.sel !== 4'd0 || bus.out_data !== din[0]) begin
      miscompares++;
      $display("FAIL mid_restart got sel=%0d d=%h exp sel=0 d=%h", bus.sel, bus.out_data, din[0]);
    end
  endtask

`ifdef ARB_BURST_EN
  task automatic test_burst();
    int exp_seq [9] = '{6, 6, 6, 6, 7, 7, 7, 7, 6};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 9'h0C0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rand_din();
      tick();
      vectors++;
      if (bus.sel !== 4'(exp_seq[i])) begin
        miscompares++;
        $display("FAIL burst step %0d got sel=%0d exp=%0d", i, bus.sel, exp_seq[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [8:0] mask;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      mask = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom);
      bus.req = 9'($urandom) & mask & 9'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      rand_din();
      tick();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL random cycle %0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.req = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 9; k++) din[k] = '0;
    test_reset();
    test_single_lane();
    test_rotation();
    test_backpressure();
    test_reset_mid();
`ifdef ARB_BURST_EN
    test_burst();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
